// File: rtl/pcie_rq_pkg.sv
// -----------------------------------------------------------------------------
// pcie_rq_pkg
// Shared definitions for the requester-request (RQ) path in legacy TLP header
// format: header DW0 field positions, the memory-read type code, and helpers
// that decode read requests from DW0.
//   tlp_len_dw(len10) : 10-bit header length -> 11-bit DW count (0 means 1024)
//   is_mem_rd(dw0)    : 1 for MRd 3DW/4DW (no data, type 5'b00000)
// -----------------------------------------------------------------------------
package pcie_rq_pkg;

    // Header DW0 field positions
    localparam int FMT_DATA_BIT = 30;   // fmt[1]: 1 = TLP carries data
    localparam int TYPE_HI      = 28;
    localparam int TYPE_LO      = 24;
    localparam int LEN_HI       = 9;
    localparam int LEN_LO       = 0;

    localparam logic [4:0] MRD_TYPE = 5'b00000;

    typedef enum logic {
        ST_SOP  = 1'b0,
        ST_BODY = 1'b1
    } rq_state_e;

    function automatic logic [10:0] tlp_len_dw(input logic [9:0] len10);
        return (len10 == 10'd0) ? 11'd1024 : {1'b0, len10};
    endfunction

    function automatic logic is_mem_rd(input logic [31:0] dw0);
        return (dw0[FMT_DATA_BIT] == 1'b0) && (dw0[TYPE_HI:TYPE_LO] == MRD_TYPE);
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// -----------------------------------------------------------------------------
// axis_skid_buf
// Two-entry AXI-Stream skid buffer with a registered upstream ready.
// An accepted beat appears on m_valid the following cycle; one beat per cycle
// is sustained while m_ready is high. The second entry absorbs the beat that
// arrives in the cycle the output stalls, so s_ready can be a flop.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   s_data/valid/ready upstream payload handshake
//   m_data/valid/ready downstream payload handshake
// -----------------------------------------------------------------------------
module axis_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             ready_q;
    logic             s_fire;
    logic             out_free;
    logic             skid_valid_d;

    assign s_ready  = ready_q;
    assign s_fire   = s_valid && ready_q;
    assign out_free = m_ready || !m_valid;

    // The skid entry fills only when a beat is accepted while the output is
    // stalled, and drains as soon as the output register frees up.
    always_comb begin
        skid_valid_d = skid_valid;
        if (out_free) begin
            skid_valid_d = 1'b0;
        end else if (s_fire) begin
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data     <= '0;
            m_valid    <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            if (out_free) begin
                if (skid_valid) begin
                    m_data  <= skid_data;
                    m_valid <= 1'b1;
                end else begin
                    m_valid <= s_fire;
                    if (s_fire) begin
                        m_data <= s_data;
                    end
                end
            end else if (s_fire) begin
                skid_data <= s_data;
            end
            skid_valid <= skid_valid_d;
            ready_q    <= !skid_valid_d;
        end
    end

endmodule

// File: rtl/rq_read_throttle.sv
// -----------------------------------------------------------------------------
// rq_read_throttle
// Throttles non-posted memory reads on the RQ stream ahead of the RQ adapter.
// A read header is admitted only when a tag is free (outstanding_req <
// MAX_TAGS) and its DW length fits the completion budget (outstanding_dw +
// len <= MAX_RD_DW). A refused header is held at the input, blocking every
// later TLP, until completion releases free enough room. All other TLPs pass
// unthrottled through a registered two-entry output stage.
//
// Ports:
//   user_clk, user_reset_n      clock, asynchronous active-low reset
//   s_axis_rq_*                 upstream TLP stream (DW0 in tdata[31:0])
//   m_axis_rq_*                 downstream TLP stream to the RQ adapter
//   cpl_done_valid/cpl_done_dw  per-request completion release pulse + length
//   outstanding_req/dw          live request and DW counters
//   throttled                   a read header is being held this cycle
//   cpl_underflow_err           sticky: a release exceeded what was outstanding
// Optional (macro RQ_THROTTLE_STATS_EN):
//   stall_cycles                saturating count of throttled cycles
//   peak_outstanding_req        high-water mark of outstanding_req
//
// FSM states:
//   state   | meaning
//   ST_SOP  | next accepted beat is the first beat of a TLP (gating applies)
//   ST_BODY | inside a multi-beat TLP, beats pass without gating
// -----------------------------------------------------------------------------
module rq_read_throttle
    import pcie_rq_pkg::*;
#(
    parameter  int DATA_WIDTH = 128,
    parameter  int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter  int MAX_TAGS   = 32,
    parameter  int MAX_RD_DW  = 2048,
    localparam int REQ_W      = $clog2(MAX_TAGS + 1),
    localparam int DW_W       = $clog2(MAX_RD_DW + 1)
) (
    input  logic                  user_clk,
    input  logic                  user_reset_n,

    input  logic [DATA_WIDTH-1:0] s_axis_rq_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_rq_tkeep,
    input  logic                  s_axis_rq_tlast,
    input  logic [3:0]            s_axis_rq_tuser,
    input  logic                  s_axis_rq_tvalid,
    output logic                  s_axis_rq_tready,

    output logic [DATA_WIDTH-1:0] m_axis_rq_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_rq_tkeep,
    output logic                  m_axis_rq_tlast,
    output logic [3:0]            m_axis_rq_tuser,
    output logic                  m_axis_rq_tvalid,
    input  logic                  m_axis_rq_tready,

    input  logic                  cpl_done_valid,
    input  logic [10:0]           cpl_done_dw,

    output logic [REQ_W-1:0]      outstanding_req,
    output logic [DW_W-1:0]       outstanding_dw,
    output logic                  throttled,
    output logic                  cpl_underflow_err
`ifdef RQ_THROTTLE_STATS_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [REQ_W-1:0]      peak_outstanding_req
`endif
);

    localparam int PAYLOAD_W = DATA_WIDTH + KEEP_WIDTH + 1 + 4;

    rq_state_e state_q, state_d;

    logic [REQ_W-1:0] req_q, req_d;
    logic [DW_W-1:0]  dw_q, dw_d;
    logic             err_q;
    logic             uflow;

    logic             is_rd;
    logic [10:0]      rd_len;
    logic             tag_ok;
    logic             dw_ok;
    logic             admit_ok;
    logic             hold;
    logic             skid_ready;
    logic             s_fire;
    logic             admit;

    logic [PAYLOAD_W-1:0] s_payload;
    logic [PAYLOAD_W-1:0] m_payload;

    logic [REQ_W:0] req_sum;
    logic [DW_W:0]  dw_sum;
    logic [DW_W:0]  rel_dw;

    // ---------------- head-beat decode and admission ----------------
    assign is_rd  = is_mem_rd(s_axis_rq_tdata[31:0]);
    assign rd_len = tlp_len_dw(s_axis_rq_tdata[LEN_HI:LEN_LO]);

    // One extra bit on each compare so the sum can never wrap.
    assign tag_ok   = ({1'b0, req_q} < (REQ_W + 1)'(MAX_TAGS));
    assign dw_ok    = (({1'b0, dw_q} + (DW_W + 1)'(rd_len)) <= (DW_W + 1)'(MAX_RD_DW));
    assign admit_ok = tag_ok && dw_ok;

    assign hold  = (state_q == ST_SOP) && s_axis_rq_tvalid && is_rd && !admit_ok;

    assign s_axis_rq_tready = skid_ready && !hold;
    assign s_fire           = s_axis_rq_tvalid && s_axis_rq_tready;
    assign admit            = s_fire && (state_q == ST_SOP) && is_rd;
    assign throttled        = hold;

    // ---------------- packet framing FSM ----------------
    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state_q <= ST_SOP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SOP: begin
                if (s_fire && !s_axis_rq_tlast) begin
                    state_d = ST_BODY;
                end
            end
            ST_BODY: begin
                if (s_fire && s_axis_rq_tlast) begin
                    state_d = ST_SOP;
                end
            end
            default: state_d = ST_SOP;
        endcase
    end

    // ---------------- outstanding counters ----------------
    // Admit and release fold into one net update; an over-release saturates
    // at zero and is flagged rather than wrapping.
    always_comb begin
        req_sum = {1'b0, req_q} + {{REQ_W{1'b0}}, admit};
        dw_sum  = {1'b0, dw_q} + (admit ? (DW_W + 1)'(rd_len) : '0);
        rel_dw  = (DW_W + 1)'(cpl_done_dw);
        uflow   = 1'b0;
        req_d   = REQ_W'(req_sum);
        dw_d    = DW_W'(dw_sum);
        if (cpl_done_valid) begin
            uflow = (req_q == '0) || ({1'b0, dw_q} < rel_dw);
            req_d = (req_sum == '0) ? '0 : REQ_W'(req_sum - (REQ_W + 1)'(1));
            dw_d  = (dw_sum < rel_dw) ? '0 : DW_W'(dw_sum - rel_dw);
        end
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            req_q <= '0;
            dw_q  <= '0;
            err_q <= 1'b0;
        end else begin
            req_q <= req_d;
            dw_q  <= dw_d;
            if (uflow) begin
                err_q <= 1'b1;
            end
        end
    end

    assign outstanding_req   = req_q;
    assign outstanding_dw    = dw_q;
    assign cpl_underflow_err = err_q;

    // ---------------- registered output stage ----------------
    assign s_payload = {s_axis_rq_tuser, s_axis_rq_tlast, s_axis_rq_tkeep, s_axis_rq_tdata};

    axis_skid_buf #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .clk     (user_clk),
        .rst_n   (user_reset_n),
        .s_data  (s_payload),
        .s_valid (s_axis_rq_tvalid && !hold),
        .s_ready (skid_ready),
        .m_data  (m_payload),
        .m_valid (m_axis_rq_tvalid),
        .m_ready (m_axis_rq_tready)
    );

    assign {m_axis_rq_tuser, m_axis_rq_tlast, m_axis_rq_tkeep, m_axis_rq_tdata} = m_payload;

`ifdef RQ_THROTTLE_STATS_EN
    // ---------------- statistics ----------------
    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            stall_cycles         <= '0;
            peak_outstanding_req <= '0;
        end else begin
            if (hold && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (req_q > peak_outstanding_req) begin
                peak_outstanding_req <= req_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rq_read_throttle.sv
`timescale 1ns/1ps
module tb_rq_read_throttle;

    localparam int DW        = 128;
    localparam int KW        = DW / 8;
    localparam int MAX_TAGS  = 4;
    localparam int MAX_RD_DW = 2048;
    localparam int RW        = $clog2(MAX_TAGS + 1);
    localparam int CW        = $clog2(MAX_RD_DW + 1);
    localparam int PW        = DW + KW + 5;

    logic          user_clk = 1'b0;
    logic          user_reset_n = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic [KW-1:0] s_tkeep = '0;
    logic          s_tlast = 1'b0;
    logic [3:0]    s_tuser = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast;
    logic [3:0]    m_tuser;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          cpl_done_valid = 1'b0;
    logic [10:0]   cpl_done_dw = '0;
    logic [RW-1:0] outstanding_req;
    logic [CW-1:0] outstanding_dw;
    logic          throttled;
    logic          cpl_underflow_err;
`ifdef RQ_THROTTLE_STATS_EN
    logic [31:0]   stall_cycles;
    logic [RW-1:0] peak_outstanding_req;
`endif

    always #5 user_clk = ~user_clk;

    rq_read_throttle #(
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .MAX_TAGS   (MAX_TAGS),
        .MAX_RD_DW  (MAX_RD_DW)
    ) dut (
        .user_clk          (user_clk),
        .user_reset_n      (user_reset_n),
        .s_axis_rq_tdata   (s_tdata),
        .s_axis_rq_tkeep   (s_tkeep),
        .s_axis_rq_tlast   (s_tlast),
        .s_axis_rq_tuser   (s_tuser),
        .s_axis_rq_tvalid  (s_tvalid),
        .s_axis_rq_tready  (s_tready),
        .m_axis_rq_tdata   (m_tdata),
        .m_axis_rq_tkeep   (m_tkeep),
        .m_axis_rq_tlast   (m_tlast),
        .m_axis_rq_tuser   (m_tuser),
        .m_axis_rq_tvalid  (m_tvalid),
        .m_axis_rq_tready  (m_tready),
        .cpl_done_valid    (cpl_done_valid),
        .cpl_done_dw       (cpl_done_dw),
        .outstanding_req   (outstanding_req),
        .outstanding_dw    (outstanding_dw),
        .throttled         (throttled),
        .cpl_underflow_err (cpl_underflow_err)
`ifdef RQ_THROTTLE_STATS_EN
        ,
        .stall_cycles         (stall_cycles),
        .peak_outstanding_req (peak_outstanding_req)
`endif
    );

    int            vectors = 0;
    int            errors  = 0;
    logic [PW-1:0] sb[$];
    logic          in_fire, out_fire, thr_seen, rand_rdy;
    logic [PW-1:0] in_pl, out_pl, exp_pl;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes on the falling edge, then update the
    // scoreboard just after the rising edge.
    task automatic cyc();
        @(negedge user_clk);
        in_fire  = s_tvalid && s_tready;
        in_pl    = {s_tuser, s_tlast, s_tkeep, s_tdata};
        out_fire = m_tvalid && m_tready;
        out_pl   = {m_tuser, m_tlast, m_tkeep, m_tdata};
        if (throttled) thr_seen = 1'b1;
        @(posedge user_clk);
        #1;
        if (in_fire) sb.push_back(in_pl);
        if (out_fire) begin
            check("sb_nonempty", 160'(sb.size() != 0), 160'(1));
            if (sb.size() != 0) begin
                exp_pl = sb.pop_front();
                check("sb_beat", 160'(out_pl), 160'(exp_pl));
            end
        end
        if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [DW-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [DW-1:0] mrd(input logic [9:0] len);
        logic [DW-1:0] d;
        d = rnd();
        d[31:0] = {22'd0, len};
        return d;
    endfunction

    function automatic logic [DW-1:0] mwr(input logic [9:0] len);
        logic [DW-1:0] d;
        d = rnd();
        d[31:0] = {22'h10_0000, len};   // fmt 3'b010, type 0
        return d;
    endfunction

    task automatic present(input logic [DW-1:0] d, input logic l);
        s_tdata  = d;
        s_tlast  = l;
        s_tkeep  = KW'($urandom);
        s_tuser  = 4'($urandom);
        s_tvalid = 1'b1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        logic done;
        done = 1'b0;
        present(d, l);
        for (int i = 0; i < 200 && !done; i++) begin
            cyc();
            if (in_fire) done = 1'b1;
        end
        s_tvalid = 1'b0;
        check("accept_in_time", 160'(done), 160'(1));
    endtask

    task automatic release_cpl(input logic [10:0] dw);
        cpl_done_valid = 1'b1;
        cpl_done_dw    = dw;
        cyc();
        cpl_done_valid = 1'b0;
        cpl_done_dw    = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || m_tvalid) && n < 400) begin
            cyc();
            n++;
        end
        check("drain_empty", 160'(sb.size()), 160'(0));
    endtask

    task automatic check_cnt(input string tag, input int req, input int dw);
        check({tag, "_req"}, 160'(outstanding_req), 160'(req));
        check({tag, "_dw"},  160'(outstanding_dw),  160'(dw));
    endtask

    initial begin
        rand_rdy = 1'b0;
        thr_seen = 1'b0;

        // ---- reset state ----
        #1 user_reset_n = 1'b0;
        #2;
        check("rst_m_tvalid", 160'(m_tvalid), 160'(0));
        check("rst_s_tready", 160'(s_tready), 160'(0));
        check_cnt("rst", 0, 0);
        check("rst_throttled", 160'(throttled), 160'(0));
        check("rst_err", 160'(cpl_underflow_err), 160'(0));
        repeat (2) @(posedge user_clk);
        @(negedge user_clk) user_reset_n = 1'b1;
        @(posedge user_clk);
        #1;
        check("rdy_after_rst", 160'(s_tready), 160'(1));

        // ---- 3-beat MWr, random backpressure ----
        rand_rdy = 1'b1;
        send_beat(mwr(10'd8), 1'b0);
        check("latency1", 160'(m_tvalid), 160'(1));
        send_beat(rnd(), 1'b0);
        send_beat(rnd(), 1'b1);
        drain();
        check("mwr_no_throttle", 160'(thr_seen), 160'(0));
        check_cnt("mwr", 0, 0);
        rand_rdy = 1'b0;
        m_tready = 1'b1;
        cyc();

        // ---- tag limit: MAX_TAGS=4 ----
        for (int i = 0; i < 4; i++) send_beat(mrd(10'd1), 1'b1);
        check_cnt("tags4", 4, 4);
        present(mrd(10'd1), 1'b1);
        #1;
        check("t5_s_tready", 160'(s_tready), 160'(0));
        check("t5_throttled", 160'(throttled), 160'(1));
        repeat (3) begin
            cyc();
            check("t5_not_accepted", 160'(in_fire), 160'(0));
        end
        check("t5_fwd4_only", 160'(sb.size()), 160'(0));
        check("t5_m_idle", 160'(m_tvalid), 160'(0));
        release_cpl(11'd1);
        check("t5_rel_req", 160'(outstanding_req), 160'(3));
        check("t5_rdy_after_rel", 160'(s_tready), 160'(1));
        cyc();
        check("t5_accepted", 160'(in_fire), 160'(1));
        s_tvalid = 1'b0;
        check("t5_req_back4", 160'(outstanding_req), 160'(4));
        present(mrd(10'd1), 1'b1);
        cyc();
        check("t6_held", 160'(in_fire), 160'(0));
        release_cpl(11'd1);
        cyc();
        check("t6_accepted", 160'(in_fire), 160'(1));
        s_tvalid = 1'b0;
        drain();
        repeat (4) release_cpl(11'd1);
        check_cnt("tags_clean", 0, 0);

        // ---- DW budget: MAX_RD_DW=2048 ----
        send_beat(mrd(10'd0), 1'b1);
        send_beat(mrd(10'd0), 1'b1);
        check_cnt("dw2048", 2, 2048);
        present(mrd(10'd1), 1'b1);
        #1;
        check("dw_held_throttled", 160'(throttled), 160'(1));
        cyc();
        check("dw_held", 160'(in_fire), 160'(0));
        release_cpl(11'd1024);
        cyc();
        check("dw_accepted", 160'(in_fire), 160'(1));
        s_tvalid = 1'b0;
        check_cnt("dw1025", 2, 1025);
        drain();
        release_cpl(11'd1024);
        release_cpl(11'd1);
        check_cnt("dw_clean", 0, 0);

        // ---- simultaneous admit and release ----
        send_beat(mrd(10'd4), 1'b1);
        send_beat(mrd(10'd4), 1'b1);
        send_beat(mrd(10'd2), 1'b1);
        check_cnt("pre_sim", 3, 10);
        present(mrd(10'd2), 1'b1);
        cpl_done_valid = 1'b1;
        cpl_done_dw    = 11'd4;
        cyc();
        check("sim_accepted", 160'(in_fire), 160'(1));
        s_tvalid       = 1'b0;
        cpl_done_valid = 1'b0;
        check_cnt("sim_net", 3, 8);
        drain();
        release_cpl(11'd4);
        release_cpl(11'd2);
        release_cpl(11'd2);
        check_cnt("sim_clean", 0, 0);
        check("no_err_yet", 160'(cpl_underflow_err), 160'(0));

        // ---- underflow ----
        release_cpl(11'd1);
        check_cnt("uflow", 0, 0);
        check("uflow_err", 160'(cpl_underflow_err), 160'(1));
        repeat (3) cyc();
        check("uflow_sticky", 160'(cpl_underflow_err), 160'(1));

        // ---- reset mid-BODY ----
        send_beat(mrd(10'd1), 1'b1);
        send_beat(mrd(10'd1), 1'b1);
        check("pre_rst_req", 160'(outstanding_req), 160'(2));
        send_beat(mwr(10'd12), 1'b0);
        send_beat(rnd(), 1'b0);
        present(rnd(), 1'b0);
        #2 user_reset_n = 1'b0;
        s_tvalid = 1'b0;
        #1;
        check("mid_rst_m_tvalid", 160'(m_tvalid), 160'(0));
        check_cnt("mid_rst", 0, 0);
        check("mid_rst_err_clr", 160'(cpl_underflow_err), 160'(0));
        sb.delete();
        repeat (2) @(posedge user_clk);
        @(negedge user_clk) user_reset_n = 1'b1;
        @(posedge user_clk);
        #1;
        send_beat(mrd(10'd1), 1'b1);
        check("post_rst_sop_req", 160'(outstanding_req), 160'(1));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
